// File: rtl/hex_seg_driver.sv
// hex_seg_driver
//   Drives one active-low 7-segment digit from the 4-bit value held by a HEX PIO
//   output register (same clock domain). Decodes the nibble, dims the digit with
//   a brightness PWM, and blinks the digit BLINK_COUNT times after each change.
//
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   digit_in    nibble from the PIO out_port
//   brightness  PWM duty select, 0 = off, all-ones = always lit
//   blank       forces all segments off without disturbing internal state
//   seg_n       registered segment outputs, active low, bit 0 = a .. bit 6 = g
//   busy        registered, high while a blink sequence is running
//
// state     | meaning
// ----------+-------------------------------------------------
// S_IDLE    | digit lit, no blink sequence in progress
// S_BLINK_OFF| digit dark for BLINK_TICKS ticks
// S_BLINK_ON| digit lit for BLINK_TICKS ticks, then count a pair

module hex_seg_driver #(
  parameter int unsigned PRESCALE    = 50000,
  parameter int unsigned BLINK_TICKS = 250,
  parameter int unsigned BLINK_COUNT = 3,
  parameter int unsigned PWM_BITS    = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [3:0]          digit_in,
  input  logic [PWM_BITS-1:0] brightness,
  input  logic                blank,
  output logic [6:0]          seg_n,
  output logic                busy
);

  // Each counter is just wide enough for its largest value.
  localparam int unsigned PRE_W  = (PRESCALE > 1)    ? $clog2(PRESCALE)    : 1;
  localparam int unsigned TCK_W  = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam int unsigned PAIR_W = (BLINK_COUNT > 1) ? $clog2(BLINK_COUNT) : 1;

  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(PRESCALE - 1);
  localparam logic [TCK_W-1:0]  TCK_LAST  = TCK_W'((BLINK_TICKS > 0) ? BLINK_TICKS - 1 : 0);
  localparam logic [PAIR_W-1:0] PAIR_LAST = PAIR_W'((BLINK_COUNT > 0) ? BLINK_COUNT - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_BLINK_OFF = 2'd1,
    S_BLINK_ON  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          cap_q, cap_d;
  logic [3:0]          shown_q, shown_d;
  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [TCK_W-1:0]    tck_q, tck_d;
  logic [PAIR_W-1:0]   pair_q, pair_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic [6:0]          seg_q, seg_d;
  logic                busy_q, busy_d;

  logic change;
  logic tick;
  logic pwm_on;

  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign change = (cap_q != shown_q);
  assign tick   = (pre_q == PRE_LAST);
  // All-ones brightness is a full-on override; pwm_q < all-ones would leave one dark slot.
  assign pwm_on = (&brightness) || (pwm_q < brightness);

  always_comb begin
    state_d = state_q;
    cap_d   = digit_in;
    shown_d = shown_q;
    pre_d   = tick ? '0 : pre_q + PRE_W'(1);
    tck_d   = tck_q;
    pair_d  = pair_q;
    pwm_d   = pwm_q + PWM_BITS'(1);

    if (change) begin
      // A change always restarts from the beginning, even mid-sequence.
      shown_d = cap_q;
      pre_d   = '0;
      tck_d   = '0;
      pair_d  = '0;
      state_d = (BLINK_COUNT == 0) ? S_IDLE : S_BLINK_OFF;
    end else begin
      case (state_q)
        S_BLINK_OFF: begin
          if (tick) begin
            if (tck_q == TCK_LAST) begin
              tck_d   = '0;
              state_d = S_BLINK_ON;
            end else begin
              tck_d = tck_q + TCK_W'(1);
            end
          end
        end
        S_BLINK_ON: begin
          if (tick) begin
            if (tck_q == TCK_LAST) begin
              tck_d = '0;
              if (pair_q == PAIR_LAST) begin
                pair_d  = '0;
                state_d = S_IDLE;
              end else begin
                pair_d  = pair_q + PAIR_W'(1);
                state_d = S_BLINK_OFF;
              end
            end else begin
              tck_d = tck_q + TCK_W'(1);
            end
          end
        end
        default: begin
          tck_d   = '0;
          pair_d  = '0;
          state_d = S_IDLE;
        end
      endcase
    end

    if (blank || (state_q == S_BLINK_OFF) || !pwm_on) begin
      seg_d = 7'h7F;
    end else begin
      seg_d = decode(shown_q);
    end
    busy_d = (state_q != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cap_q   <= '0;
      shown_q <= '0;
      pre_q   <= '0;
      tck_q   <= '0;
      pair_q  <= '0;
      pwm_q   <= '0;
      seg_q   <= 7'h7F;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
      shown_q <= shown_d;
      pre_q   <= pre_d;
      tck_q   <= tck_d;
      pair_q  <= pair_d;
      pwm_q   <= pwm_d;
      seg_q   <= seg_d;
      busy_q  <= busy_d;
    end
  end

  assign seg_n = seg_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_hex_seg_driver.sv
module tb_hex_seg_driver;

  localparam int P_PRESCALE = 4;
  localparam int P_TICKS    = 2;
  localparam int P_COUNT    = 2;
  localparam int PH         = P_PRESCALE * P_TICKS;
  localparam int SEQ        = 2 * P_COUNT * PH;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] digit_a = 4'h0;
  logic [3:0] digit_z = 4'h0;
  logic [3:0] bright = 4'hF;
  logic       blank = 1'b0;
  logic [6:0] seg_a, seg_z;
  logic       busy_a, busy_z;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hex_seg_driver #(.PRESCALE(P_PRESCALE), .BLINK_TICKS(P_TICKS), .BLINK_COUNT(P_COUNT), .PWM_BITS(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .digit_in(digit_a), .brightness(bright),
    .blank(blank), .seg_n(seg_a), .busy(busy_a));

  hex_seg_driver #(.PRESCALE(P_PRESCALE), .BLINK_TICKS(P_TICKS), .BLINK_COUNT(0), .PWM_BITS(4)) dut_z (
    .clk(clk), .reset_n(reset_n), .digit_in(digit_z), .brightness(bright),
    .blank(blank), .seg_n(seg_z), .busy(busy_z));

  typedef struct {
    logic [3:0] digit;
    logic [6:0] exp_seg;
  } vec_t;

  vec_t vecs [16];

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Expected seg_n k clocks after a change driven just after edge N.
  function automatic logic [6:0] m_seg(input int k, input logic [6:0] oldv, input logic [6:0] newv);
    if (k < 3) return oldv;
    if (k >= 3 + SEQ) return newv;
    return (((k - 3) / PH) % 2 == 0) ? 7'h7F : newv;
  endfunction

  function automatic logic m_busy(input int k, input logic oldb);
    if (k < 3) return oldb;
    return (k < 3 + SEQ);
  endfunction

  int lit;
  logic [6:0] e;

  initial begin
    vecs[0]  = '{4'h0, 7'h40}; vecs[1]  = '{4'h1, 7'h79};
    vecs[2]  = '{4'h2, 7'h24}; vecs[3]  = '{4'h3, 7'h30};
    vecs[4]  = '{4'h4, 7'h19}; vecs[5]  = '{4'h5, 7'h12};
    vecs[6]  = '{4'h6, 7'h02}; vecs[7]  = '{4'h7, 7'h78};
    vecs[8]  = '{4'h8, 7'h00}; vecs[9]  = '{4'h9, 7'h10};
    vecs[10] = '{4'hA, 7'h08}; vecs[11] = '{4'hB, 7'h03};
    vecs[12] = '{4'hC, 7'h46}; vecs[13] = '{4'hD, 7'h21};
    vecs[14] = '{4'hE, 7'h06}; vecs[15] = '{4'hF, 7'h0E};

    // Reset state
    step(2);
    check("reset_seg_a", {1'b0, seg_a}, 8'h7F);
    check("reset_busy_a", {7'b0, busy_a}, 8'h00);
    check("reset_seg_z", {1'b0, seg_z}, 8'h7F);
    reset_n = 1'b1;
    step(3);
    check("post_reset_seg_a", {1'b0, seg_a}, 8'h40);
    check("post_reset_busy_a", {7'b0, busy_a}, 8'h00);
    check("post_reset_seg_z", {1'b0, seg_z}, 8'h40);

    // Decode sweep, no-blink instance
    for (int v = 0; v < 16; v++) begin
      digit_z = vecs[v].digit;
      step(3);
      check($sformatf("decode_%0h", vecs[v].digit), {1'b0, seg_z}, {1'b0, vecs[v].exp_seg});
      for (int k = 0; k < 3; k++) begin
        step(1);
        check($sformatf("decode_busy_%0h", vecs[v].digit), {7'b0, busy_z}, 8'h00);
      end
    end

    // Single change 0 -> A
    digit_a = 4'hA;
    for (int k = 1; k <= 40; k++) begin
      step(1);
      check($sformatf("single_seg_k%0d", k), {1'b0, seg_a}, {1'b0, m_seg(k, 7'h40, 7'h08)});
      check($sformatf("single_busy_k%0d", k), {7'b0, busy_a}, {7'b0, m_busy(k, 1'b0)});
    end

    // Same-value rewrite
    digit_a = 4'hA;
    for (int k = 1; k <= 10; k++) begin
      step(1);
      check($sformatf("same_seg_k%0d", k), {1'b0, seg_a}, 8'h08);
      check($sformatf("same_busy_k%0d", k), {7'b0, busy_a}, 8'h00);
    end

    // Restart: A -> 5, then 5 -> 3 twelve clocks later
    digit_a = 4'h5;
    for (int k = 1; k <= 12; k++) begin
      step(1);
      check($sformatf("restart_a_seg_k%0d", k), {1'b0, seg_a}, {1'b0, m_seg(k, 7'h08, 7'h12)});
      check($sformatf("restart_a_busy_k%0d", k), {7'b0, busy_a}, {7'b0, m_busy(k, 1'b0)});
    end
    digit_a = 4'h3;
    for (int j = 1; j <= 40; j++) begin
      step(1);
      e = (j < 3) ? m_seg(12 + j, 7'h08, 7'h12) : m_seg(j, 7'h12, 7'h30);
      check($sformatf("restart_b_seg_j%0d", j), {1'b0, seg_a}, {1'b0, e});
      check($sformatf("restart_b_busy_j%0d", j), {7'b0, busy_a}, {7'b0, m_busy(j, 1'b1)});
    end

    // Blank during BLINK_ON
    digit_a = 4'h7;
    for (int k = 1; k <= 40; k++) begin
      step(1);
      e = (k >= 13 && k <= 16) ? 7'h7F : m_seg(k, 7'h30, 7'h78);
      check($sformatf("blank_seg_k%0d", k), {1'b0, seg_a}, {1'b0, e});
      check($sformatf("blank_busy_k%0d", k), {7'b0, busy_a}, {7'b0, m_busy(k, 1'b0)});
      if (k == 12) blank = 1'b1;
      if (k == 16) blank = 1'b0;
    end

    // PWM
    bright = 4'h4;
    step(1);
    lit = 0;
    for (int k = 0; k < 32; k++) begin
      if (seg_a != 7'h7F) lit++;
      step(1);
    end
    check("pwm4_lit_count", 8'(lit), 8'd8);
    bright = 4'h0;
    step(1);
    lit = 0;
    for (int k = 0; k < 32; k++) begin
      if (seg_a != 7'h7F) lit++;
      step(1);
    end
    check("pwm0_lit_count", 8'(lit), 8'd0);
    bright = 4'hF;
    step(1);
    for (int k = 0; k < 4; k++) begin
      check("pwm_full_seg", {1'b0, seg_a}, 8'h78);
      step(1);
    end

    // Reset mid-blink
    digit_a = 4'h9;
    step(6);
    check("midblink_busy_before", {7'b0, busy_a}, 8'h01);
    #2 reset_n = 1'b0;
    #1;
    check("midblink_reset_seg", {1'b0, seg_a}, 8'h7F);
    check("midblink_reset_busy", {7'b0, busy_a}, 8'h00);
    digit_a = 4'h0;
    digit_z = 4'h0;
    step(2);
    reset_n = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step(1);
      check($sformatf("after_reset_seg_k%0d", k), {1'b0, seg_a}, 8'h40);
      check($sformatf("after_reset_busy_k%0d", k), {7'b0, busy_a}, 8'h00);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
